// File: rtl/rv32i_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rv32i_mem_pkg                                              |
// | Brief   : Shared encodings for the wait-state data memory.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rv32i_mem_pkg;

    localparam logic [1:0] c_sz_byte = 2'b00;
    localparam logic [1:0] c_sz_half = 2'b01;
    localparam logic [1:0] c_sz_word = 2'b10;
    localparam logic [1:0] c_sz_ill  = 2'b11;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [31:0] c_print_addr_dflt = 32'h8000_0000;

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            c_sz_byte: lane_mask = 4'b0001 << off;
            c_sz_half: lane_mask = 4'b0011 << off;
            default:   lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        misaligned = (sz == c_sz_ill) ||
                     ((sz == c_sz_half) && off[0]) ||
                     ((sz == c_sz_word) && (off != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : byte_fifo                                                  |
// | Brief   : Byte-wide FIFO; a push on full is taken when a pop occurs. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               din,
    output logic                     full,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    c_full     = (AW+1)'(DEPTH);
    localparam logic [AW:0]    c_cnt_one  = 1;
    localparam logic [AW-1:0]  c_ptr_one  = 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_do_pop;
    logic          w_do_push;

    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == c_full);
    assign count     = r_cnt;
    assign dout      = r_mem[r_rp];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + c_ptr_one;
            if (w_do_pop)  r_rp <= r_rp + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wp] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_dmem_ws.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rv32i_dmem_ws                                              |
// | Brief   : Byte-lane data memory with wait states and console FIFO.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rv32i_dmem_ws
    import rv32i_mem_pkg::*;
#(
    parameter int          CAP_WORDS   = 1024,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] PRINT_ADDR  = c_print_addr_dflt,
    parameter int          FIFO_DEPTH  = 4,
    parameter string       INIT_FILE   = "./test.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        breq,
    input  logic        bwr,
    input  logic [31:0] baddr,
    input  logic [1:0]  bsz,
    input  logic [31:0] bdi,
    output logic [31:0] bdo,
    output logic        mrdy,
    output logic        merr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int IW = $clog2(CAP_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [3:0]    r_cnt;
    logic          r_wr;
    logic [31:0]   r_addr;
    logic [1:0]    r_sz;
    logic [31:0]   r_di;
    logic [31:0]   r_do;
    logic          r_err;

    logic [1:0]    w_off;
    logic [29:0]   w_waddr;
    logic [IW-1:0] w_idx;
    logic          w_is_print;
    logic          w_in_rng;
    logic          w_err;
    logic          w_fifo_wr;
    logic          w_stall;
    logic          w_fire;
    logic          w_mem_we;
    logic [3:0]    w_lanes;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rword;
    logic [31:0]   w_shift;
    logic [31:0]   w_rdata;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;

    assign w_off      = r_addr[1:0];
    assign w_waddr    = r_addr[31:2];
    assign w_idx      = r_addr[IW+1:2];
    assign w_is_print = (w_waddr == PRINT_ADDR[31:2]);
    assign w_in_rng   = ({2'b00, w_waddr} < 32'(CAP_WORDS));
    assign w_err      = misaligned(r_sz, w_off) || !(w_is_print || w_in_rng);
    assign w_fifo_wr  = r_wr && w_is_print && !w_err;
    // Full means non-empty, so tx_ready alone tells us a slot frees this edge.
    assign w_stall    = w_fifo_wr && w_full && !tx_ready;
    assign w_fire     = (r_state == c_st_wait) && (r_cnt == 4'd0) && !w_stall;
    assign w_mem_we   = w_fire && r_wr && !w_err && !w_is_print;
    assign w_lanes    = lane_mask(r_sz, w_off);
    assign w_wdata    = r_di << {w_off, 3'b000};
    assign w_shift    = w_rword >> {w_off, 3'b000};

    always_comb begin
        w_rdata = 32'h0;
        if (!r_wr && !w_err) begin
            if (w_is_print) begin
                w_rdata = 32'(w_count);
            end else begin
                case (r_sz)
                    c_sz_byte: w_rdata = {24'h0, w_shift[7:0]};
                    c_sz_half: w_rdata = {16'h0, w_shift[15:0]};
                    default:   w_rdata = w_shift;
                endcase
            end
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0] r_mem [CAP_WORDS];

        always_ff @(posedge clk) begin
            if (w_mem_we && w_lanes[b]) r_mem[w_idx] <= w_wdata[8*b +: 8];
        end

        assign w_rword[8*b +: 8] = r_mem[w_idx];
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_fire && w_fifo_wr),
        .din   (r_di[7:0]),
        .full  (w_full),
        .pop   (tx_ready),
        .dout  (tx_data),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (breq) w_next = c_st_wait;
            c_st_wait: if ((r_cnt == 4'd0) && !w_stall) w_next = c_st_done;
            c_st_done: w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    always_comb begin
        mrdy     = (r_state == c_st_done);
        merr     = (r_state == c_st_done) && r_err;
        bdo      = r_do;
        tx_valid = !w_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= 4'd0;
            r_wr   <= 1'b0;
            r_addr <= 32'h0;
            r_sz   <= c_sz_byte;
            r_di   <= 32'h0;
            r_do   <= 32'h0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (breq) begin
                        r_cnt  <= 4'(WAIT_STATES);
                        r_wr   <= bwr;
                        r_addr <= baddr;
                        r_sz   <= bsz;
                        r_di   <= bdi;
                    end
                end
                c_st_wait: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (!w_stall) begin
                        r_do  <= w_rdata;
                        r_err <= w_err;
                    end
                end
                default: begin
                    r_do  <= 32'h0;
                    r_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
